// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared constants and types for the hh:mm:ss time-of-day stage
package time_pkg;

  localparam int MS_W     = 10;
  localparam int MS_MAX   = 999;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam int SS_W = 6;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_FIELD_W = 2 * BCD_DIGIT_W;
  localparam int BCD_SS_LSB  = 0;
  localparam int BCD_MM_LSB  = BCD_SS_LSB + BCD_FIELD_W;
  localparam int BCD_HH_LSB  = BCD_MM_LSB + BCD_FIELD_W;
  localparam int BCD_TIME_W  = 3 * BCD_FIELD_W;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_BUSY  = 1'b1
  } preset_state_t;

endpackage

// File: rtl/bin2bcd_2digit.sv
// rtl/bin2bcd_2digit.sv - registered 0..59 binary to two-digit BCD converter
module bin2bcd_2digit (
  input  logic       clk,
  input  logic       resett,
  input  logic [5:0] bin,
  output logic [7:0] bcd
);
  import time_pkg::*;

  logic [BCD_DIGIT_W-1:0] tens;
  logic [5:0]             rem;

  // Constant-divisor compare chain; inputs never exceed 59.
  always_comb begin
    tens = '0;
    rem  = bin;
    if (bin >= 6'd50) begin
      tens = 4'd5;
      rem  = bin - 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      rem  = bin - 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      rem  = bin - 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      rem  = bin - 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      rem  = bin - 6'd10;
    end
  end

  always_ff @(posedge clk) begin
    if (resett) begin
      bcd <= '0;
    end else begin
      bcd <= {tens, rem[BCD_DIGIT_W-1:0]};
    end
  end

endmodule

// File: rtl/hms_clock_counter.sv
// rtl/hms_clock_counter.sv - hh:mm:ss counter driven by ms wraps, with preset handshake and BCD output
module hms_clock_counter #(
  parameter int MS_W     = time_pkg::MS_W,
  parameter int MS_MAX   = time_pkg::MS_MAX,
  parameter int HOUR_MAX = time_pkg::HOUR_MAX
) (
  input  logic            clk,
  input  logic            resett,
  input  logic            reconfig_en,
  input  logic [MS_W-1:0] ms_in,
  input  logic            set_valid,
  input  logic [4:0]      set_hh,
  input  logic [5:0]      set_mm,
  input  logic [5:0]      set_ss,
  output logic            set_ready,
  output logic            set_err,
  output logic [4:0]      hh,
  output logic [5:0]      mm,
  output logic [5:0]      ss,
  output logic            sec_tick,
  output logic [23:0]     bcd_time
);
  import time_pkg::*;

  logic [MS_W-1:0] ms_prev;
  logic            rc_d;
  logic            wrap;

  preset_state_t   state;
  preset_state_t   state_next;
  logic            accept;
  logic            load;
  logic            preset_ok;
  logic            pre_ok;
  logic [4:0]      pre_hh;
  logic [5:0]      pre_mm;
  logic [5:0]      pre_ss;

  logic            ss_last;
  logic            mm_last;
  logic            hh_last;

  logic [7:0]      hh_bcd;
  logic [7:0]      mm_bcd;
  logic [7:0]      ss_bcd;

  // The upstream counter clears one cycle after reconfig_en, so both the
  // live and delayed reconfig_en must veto the 999 -> 0 edge.
  assign wrap = (ms_prev == MS_W'(MS_MAX)) && (ms_in == '0) && !reconfig_en && !rc_d;

  assign preset_ok = (set_hh <= 5'(HOUR_MAX)) && (set_mm <= 6'(MIN_MAX))
                   && (set_ss <= 6'(SEC_MAX));

  assign ss_last = (ss == 6'(SEC_MAX));
  assign mm_last = (mm == 6'(MIN_MAX));
  assign hh_last = (hh == 5'(HOUR_MAX));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    case (state)
      ST_READY: begin
        if (set_valid && set_ready) begin
          accept     = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        load       = pre_ok;
        state_next = ST_READY;
      end
      default: state_next = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resett) begin
      state     <= ST_READY;
      set_ready <= 1'b0;
      set_err   <= 1'b0;
      pre_ok    <= 1'b0;
      pre_hh    <= '0;
      pre_mm    <= '0;
      pre_ss    <= '0;
    end else begin
      state     <= state_next;
      set_ready <= (state_next == ST_READY);
      set_err   <= accept && !preset_ok;
      if (accept) begin
        pre_ok <= preset_ok;
        pre_hh <= set_hh;
        pre_mm <= set_mm;
        pre_ss <= set_ss;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resett) begin
      ms_prev <= '0;
      rc_d    <= 1'b0;
    end else begin
      ms_prev <= ms_in;
      rc_d    <= reconfig_en;
    end
  end

  // A valid load overrides a coincident wrap; that second is dropped.
  always_ff @(posedge clk) begin
    if (resett) begin
      hh       <= '0;
      mm       <= '0;
      ss       <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= wrap && !load;
      if (load) begin
        hh <= pre_hh;
        mm <= pre_mm;
        ss <= pre_ss;
      end else if (wrap) begin
        ss <= ss_last ? '0 : ss + 6'd1;
        if (ss_last) begin
          mm <= mm_last ? '0 : mm + 6'd1;
          if (mm_last) begin
            hh <= hh_last ? '0 : hh + 5'd1;
          end
        end
      end
    end
  end

  bin2bcd_2digit u_hh_bcd (
    .clk    (clk),
    .resett (resett),
    .bin    ({1'b0, hh}),
    .bcd    (hh_bcd)
  );

  bin2bcd_2digit u_mm_bcd (
    .clk    (clk),
    .resett (resett),
    .bin    (mm),
    .bcd    (mm_bcd)
  );

  bin2bcd_2digit u_ss_bcd (
    .clk    (clk),
    .resett (resett),
    .bin    (ss),
    .bcd    (ss_bcd)
  );

  assign bcd_time[BCD_HH_LSB +: BCD_FIELD_W] = hh_bcd;
  assign bcd_time[BCD_MM_LSB +: BCD_FIELD_W] = mm_bcd;
  assign bcd_time[BCD_SS_LSB +: BCD_FIELD_W] = ss_bcd;

endmodule

// File: doc/hms_clock_counter.md
Name: hms_clock_counter

Overview:
- Time-of-day stage directly downstream of the millisecond counter.
- Watches the 0..999 ms count and detects each 999 -> 0 wrap as one elapsed second. Maintains hours:minutes:seconds (24 h wrap).
- Accepts a preset time from the UART control path through a valid/ready handshake.
- Presents binary and BCD time to the UART reporting logic.

Parameters:
- MS_W, 10, width of incoming ms count
- MS_MAX, 999, terminal ms value; wrap MS_MAX -> 0 marks one second
- HOUR_MAX, 23, terminal hour value

Ports:
- clk  in  1  system clock (50 MHz)
- resett  in  1  synchronous, active-high reset
- reconfig_en  in  1  PLL reconfiguration in progress; same signal that clears the ms counter
- ms_in  in  MS_W  millisecond count from upstream counter
- set_valid  in  1  preset request
- set_hh  in  5  preset hours
- set_mm  in  6  preset minutes
- set_ss  in  6  preset seconds
- set_ready  out  1  block can accept a preset this cycle
- set_err  out  1  one-cycle pulse: accepted preset was out of range and discarded
- hh  out  5  hours, binary
- mm  out  6  minutes, binary
- ss  out  6  seconds, binary
- sec_tick  out  1  one-cycle pulse, high in the first cycle hh/mm/ss show the new second
- bcd_time  out  24  {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}, 4 bits each

Behaviour:
- Clock and reset: one clock, clk. Reset resett is synchronous and active-high.
- Reset values: hh = mm = ss = 0; sec_tick = 0; set_err = 0; set_ready = 0; bcd_time = 0; internal ms_prev = 0; rc_d = 0. set_ready rises in the first cycle after resett deasserts.
- Wrap detection: ms_prev <= ms_in every cycle. wrap = (ms_prev == MS_MAX) && (ms_in == 0) && !reconfig_en && !rc_d, where rc_d is reconfig_en delayed one cycle. The upstream counter clears one cycle after reconfig_en, so a 999 -> 0 caused by reconfiguration never counts as a second.
- Any other jump (e.g. 500 -> 0, 998 -> 0) is ignored and is not a wrap.
- Increment on wrap, in the cycle wrap is true, registered at the clock edge:
  - ss increments; ss 59 -> 0 carries to mm.
  - mm 59 -> 0 carries to hh.
  - hh HOUR_MAX -> 0.
  - sec_tick = 1 in the following cycle only.
- Latency: ms_in = 0 presented in cycle N -> new hh/mm/ss and sec_tick in N+1; matching bcd_time in N+2.
- BCD stage: registered. Tens and units of each field come from a constant-divisor compare chain (values < 60). No multi-cycle division.
- Preset handshake and FSM, states READY and BUSY:
  - READY: set_ready = 1. When set_valid && set_ready, sample set_* and go to BUSY.
  - BUSY: set_ready = 0, lasts exactly one cycle. If set_hh <= HOUR_MAX && set_mm <= 59 && set_ss <= 59, load hh/mm/ss. Otherwise pulse set_err and keep the current time. Return to READY.
  - Loaded time appears on hh/mm/ss 2 cycles after the accepting cycle. bcd_time follows one cycle later.
  - A load never asserts sec_tick.
- Simultaneous load and wrap in the same cycle: the load wins and that second is dropped (no tick). An invalid preset in that cycle does not suppress the wrap.
- set_valid while set_ready = 0 is ignored; the requester must hold it.
- reconfig_en high: hh/mm/ss hold, the handshake still operates, wraps are suppressed as above.
- Reset mid-operation, including during BUSY: all state returns to reset values at the next edge, and a pending preset is discarded.

Decomposition:
- Shared package (time_pkg): constants MS_MAX, SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX, field widths, BCD field offsets in bcd_time.
- One sub-module: bin2bcd_2digit. Registered, 1-cycle latency, 0..59 in -> 8-bit BCD out. Instantiated three times.

Test Plan:
- Reset/idle: hold resett 3 cycles -> all outputs 0, set_ready = 0. After release, set_ready = 1 in the next cycle.
- Normal wrap: drive ms_in 998, 999, 0 -> sec_tick pulses once, ss = 1 one cycle after ms_in = 0, bcd_time = 24'h000001 one cycle later. Hold ms_in = 0 for 5 more cycles -> no further ticks.
- Cascade: preset 23:59:59 and check set_ready low for 1 cycle. Then wrap ms -> hh/mm/ss = 0/0/0, bcd_time = 0, exactly one sec_tick.
- Reconfig suppression: ms_in = 999 with reconfig_en = 1, then ms_in = 0 next cycle with reconfig_en = 0 -> no tick, time unchanged.
- Invalid preset: set_hh = 24, set_mm = 10, set_ss = 5 -> set_err pulse one cycle after acceptance, time unchanged. set_ss = 60 -> same result.
- Collision: time 00:00:10, valid preset 12:34:56 accepted so its load coincides with a wrap -> time = 12:34:56, no sec_tick. Next wrap -> 12:34:57.
